// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic t_clk,
  input  logic reset,
  input  logic clr,
  output logic bit_end
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             bit_end_d;

  // bit_end is registered, so it is computed from the next count value
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end
    bit_end_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge t_clk) begin
    if (reset) begin
      cnt_q   <= '0;
      bit_end <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_end <= bit_end_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, LSB-first data, optional parity, STOP_BITS stop bits.
// Parity stage is built only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic              t_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              d_out,
  output logic              tx_status
);

  localparam int unsigned IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  tx_state_t         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic              bit_end;
  logic              baud_clr;

`ifdef UART_TX_PARITY_EN
  logic parity_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  // Holding the divider cleared in IDLE aligns every bit period to the handshake edge
  assign baud_clr = (state_q == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .t_clk  (t_clk),
    .reset  (reset),
    .clr    (baud_clr),
    .bit_end(bit_end)
  );

  always_ff @(posedge t_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      d_out     <= UART_IDLE_LVL;
      tx_ready  <= 1'b0;
      tx_status <= 1'b0;
      shift_q   <= '0;
      bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      tx_status <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            state_q   <= START;
            d_out     <= ~UART_IDLE_LVL;
            tx_ready  <= 1'b0;
            shift_q   <= tx_data;
            bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= (^tx_data) ^ PARITY_ODD;
`endif
          end else begin
            d_out    <= UART_IDLE_LVL;
            tx_ready <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            d_out   <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx_q == LAST_BIT) begin
              bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q   <= PARITY;
              d_out     <= parity_q;
`else
              state_q   <= STOP;
              d_out     <= UART_IDLE_LVL;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
              d_out     <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            d_out   <= UART_IDLE_LVL;
          end
        end
`endif
        // bit_idx_q doubles as the stop-bit counter
        STOP: begin
          if (bit_end) begin
            if (bit_idx_q == LAST_STOP) begin
              state_q   <= IDLE;
              bit_idx_q <= '0;
              tx_status <= 1'b1;
              tx_ready  <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          d_out    <= UART_IDLE_LVL;
          tx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: two instances (1 and 2 stop bits), CLKS_PER_BIT=4.
module tb_uart_tx_frame;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] data1, data2;
  logic       valid1, valid2;
  logic       ready1, ready2;
  logic       dout1, dout2;
  logic       status1, status2;

  int total = 0;
  int bad   = 0;

  uart_tx_frame #(
    .DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1'b0)
  ) u_dut1 (
    .t_clk(clk), .reset(reset), .tx_data(data1), .tx_valid(valid1),
    .tx_ready(ready1), .d_out(dout1), .tx_status(status1)
  );

  uart_tx_frame #(
    .DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1'b1)
  ) u_dut2 (
    .t_clk(clk), .reset(reset), .tx_data(data2), .tx_valid(valid2),
    .tx_ready(ready2), .d_out(dout2), .tx_status(status2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic f_dout(int sel);
    return (sel == 1) ? dout1 : dout2;
  endfunction

  function automatic logic f_ready(int sel);
    return (sel == 1) ? ready1 : ready2;
  endfunction

  function automatic logic f_status(int sel);
    return (sel == 1) ? status1 : status2;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 1) begin
      valid1 = v;
      data1  = d;
    end else begin
      valid2 = v;
      data2  = d;
    end
  endtask

  // Present a word and return just after the handshake edge
  task automatic send(input int sel, input logic [7:0] d);
    int n;
    @(negedge clk);
    drive(sel, 1'b1, d);
    n = 0;
    while (f_ready(sel) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hs_wait", 32'(n < 200), 32'd1);
    @(posedge clk);
  endtask

  // Check a full frame; hold keeps tx_valid high and swaps tx_data at frame clk 10
  task automatic check_frame(input int sel, input logic [7:0] d, input int nstop,
                             input logic podd, input logic hold,
                             input logic [7:0] nxt, input string tag);
    int   nb;
    int   cyc;
    logic eb;
    nb  = 1 + 8 + P + nstop;
    cyc = 0;
    #1;
    if (!hold) drive(sel, 1'b0, d);
    for (int b = 0; b < nb; b++) begin
      if (b == 0)                eb = 1'b0;
      else if (b <= 8)           eb = d[b-1];
      else if (P == 1 && b == 9) eb = (^d) ^ podd;
      else                       eb = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        cyc++;
        if (hold && cyc == 10) drive(sel, 1'b1, nxt);
        chk($sformatf("%s bit%0d c%0d", tag, b, c), 32'(f_dout(sel)), 32'(eb));
        if (c == 0) begin
          chk($sformatf("%s rdy bit%0d", tag, b), 32'(f_ready(sel)), 32'd0);
          chk($sformatf("%s sts bit%0d", tag, b), 32'(f_status(sel)), 32'd0);
        end
      end
    end
    @(negedge clk);
    chk({tag, " status"},    32'(f_status(sel)), 32'd1);
    chk({tag, " ready_end"}, 32'(f_ready(sel)),  32'd1);
    chk({tag, " idle_high"}, 32'(f_dout(sel)),   32'd1);
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst dout1",   32'(dout1),   32'd1);
    chk("rst ready1",  32'(ready1),  32'd0);
    chk("rst status1", 32'(status1), 32'd0);
    chk("rst dout2",   32'(dout2),   32'd1);
    chk("rst ready2",  32'(ready2),  32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready after rst", 32'(ready1), 32'd1);

    // Single frame 0xA5, even parity when enabled
    send(1, 8'hA5);
    check_frame(1, 8'hA5, 1, 1'b0, 1'b0, 8'h00, "a5");
    @(negedge clk);
    chk("a5 status_1cyc", 32'(status1), 32'd0);

    // Two stop bits, odd parity when enabled
    send(2, 8'hA5);
    check_frame(2, 8'hA5, 2, 1'b1, 1'b0, 8'h00, "a5s2");
    send(2, 8'h3C);
    check_frame(2, 8'h3C, 2, 1'b1, 1'b0, 8'h00, "3cs2");
    @(negedge clk);
    chk("3cs2 status_1cyc", 32'(status2), 32'd0);

    // Back-to-back 0x00 then 0xFF with tx_valid held
    send(1, 8'h00);
    check_frame(1, 8'h00, 1, 1'b0, 1'b1, 8'hFF, "b2b0");
    @(posedge clk);
    check_frame(1, 8'hFF, 1, 1'b0, 1'b0, 8'h00, "b2b1");

    // Data changed mid-frame is ignored; new word taken on the status cycle
    send(1, 8'h5A);
    check_frame(1, 8'h5A, 1, 1'b0, 1'b1, 8'hC3, "mid0");
    @(posedge clk);
    check_frame(1, 8'hC3, 1, 1'b0, 1'b0, 8'h00, "mid1");

    // Reset at frame clk 15 of a 0x00 frame (line low there)
    send(1, 8'h00);
    #1 drive(1, 1'b0, 8'h00);
    repeat (14) @(negedge clk);
    @(negedge clk);
    chk("abort pre dout", 32'(dout1), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort dout",   32'(dout1),   32'd1);
    chk("abort status", 32'(status1), 32'd0);
    chk("abort ready",  32'(ready1),  32'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (status1 === 1'b1) pulses++;
    end
    chk("abort no_status", 32'(pulses), 32'd0);
    chk("abort idle dout", 32'(dout1),  32'd1);
    send(1, 8'h96);
    check_frame(1, 8'h96, 1, 1'b0, 1'b0, 8'h00, "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
